// File: rtl/div_unit_pkg.sv
// Shared definitions for the multicycle signed divider: state encoding,
// default datapath width and the width of the step counter.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and report the quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] divisor_ext;

    // Unsigned compare-and-subtract on a widened copy so nothing overflows.
    always_comb begin
        shifted     = {rem_in, bit_in};
        divisor_ext = {2'b00, divisor};
        q_bit       = (shifted >= divisor_ext);
        rem_out     = (WIDTH+1)'(q_bit ? (shifted - divisor_ext) : shifted);
    end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider with a start/done handshake. Works on operand
// magnitudes with one restoring step per cycle, then restores the signs:
// the quotient truncates toward zero, the remainder follows the dividend.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             div_control,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_end,
    output logic             div_zero,
    output logic             busy
);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dvs;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     step_rem;
    logic               step_q;

    assign abs_a = a_in[WIDTH-1] ? -a_in : a_in;
    assign abs_b = b_in[WIDTH-1] ? -b_in : b_in;
    assign busy  = (state != IDLE);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .divisor (dvs),
        .bit_in  (quo[WIDTH-1]),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; starts are only accepted from IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (div_control) next_state = (b_in == '0) ? DONE : CALC;
            CALC: if (cnt == CNT_W'(1)) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, sign fix-up and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            div_end  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_control) begin
                        sign_a <= a_in[WIDTH-1];
                        sign_b <= b_in[WIDTH-1];
                        if (b_in == '0) begin
                            div_zero <= 1'b1;
                            div_end  <= 1'b1;
                        end else begin
                            div_zero <= 1'b0;
                            quo      <= abs_a;
                            dvs      <= abs_b;
                            rem      <= '0;
                            cnt      <= CNT_W'(WIDTH);
                        end
                    end
                end
                CALC: begin
                    rem <= step_rem;
                    quo <= {quo[WIDTH-2:0], step_q};
                    cnt <= cnt - CNT_W'(1);
                end
                FIX: begin
                    lo_out  <= (sign_a ^ sign_b) ? -quo : quo;
                    hi_out  <= WIDTH'(sign_a ? -rem : rem);
                    div_end <= 1'b1;
                end
                DONE: begin
                    div_end <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        div_control;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_end;
    logic        div_zero;
    logic        busy;

    int checks;
    int failures;

    div_unit dut (
        .clk         (clk),
        .reset       (reset),
        .a_in        (a_in),
        .b_in        (b_in),
        .div_control (div_control),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .div_end     (div_end),
        .div_zero    (div_zero),
        .busy        (busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-cycle start; returns 1 ns after the sampling edge (edge 1).
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        a_in        = a;
        b_in        = b;
        div_control = 1'b1;
        @(posedge clk);
        #1;
        div_control = 1'b0;
    endtask

    // Count edges (start edge = 1) until div_end is seen, bounded.
    task automatic wait_done(input int first, output int edges);
        edges = first;
        while (!div_end && edges < 80) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset;
        reset       = 1'b0;
        div_control = 1'b0;
        a_in        = '0;
        b_in        = '0;
        #12;
        checks++; if (hi_out !== 32'd0) begin failures++; $display("[TB] FAIL reset_hi: got %h expected %h", hi_out, 32'd0); end
        checks++; if (lo_out !== 32'd0) begin failures++; $display("[TB] FAIL reset_lo: got %h expected %h", lo_out, 32'd0); end
        checks++; if (div_end !== 1'b0) begin failures++; $display("[TB] FAIL reset_end: got %b expected 0", div_end); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("[TB] FAIL reset_zero: got %b expected 0", div_zero); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic;
        int edges;
        start_op(32'd100, 32'd7);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy_run: got %b expected 1", busy); end
        wait_done(1, edges);
        checks++; if (edges !== 34) begin failures++; $display("[TB] FAIL basic_latency: got %0d expected %0d", edges, 34); end
        checks++; if (lo_out !== 32'd14) begin failures++; $display("[TB] FAIL basic_lo: got %h expected %h", lo_out, 32'd14); end
        checks++; if (hi_out !== 32'd2) begin failures++; $display("[TB] FAIL basic_hi: got %h expected %h", hi_out, 32'd2); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("[TB] FAIL basic_zero: got %b expected 0", div_zero); end
        @(posedge clk);
        #1;
        checks++; if (div_end !== 1'b0) begin failures++; $display("[TB] FAIL basic_end_width: got %b expected 0", div_end); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_idle: got %b expected 0", busy); end
    endtask

    task automatic test_signs;
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        logic [31:0] tq [4];
        logic [31:0] tr [4];
        int edges;
        ta = '{32'hFFFFFF9C, 32'd100,    32'h80000000, 32'd3};
        tb = '{32'd7,        32'hFFFFFFF9, 32'hFFFFFFFF, 32'd10};
        tq = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'h80000000, 32'd0};
        tr = '{32'hFFFFFFFE, 32'd2,      32'd0,        32'd3};
        for (int i = 0; i < 4; i++) begin
            start_op(ta[i], tb[i]);
            wait_done(1, edges);
            checks++; if (edges !== 34) begin failures++; $display("[TB] FAIL signs_latency[%0d]: got %0d expected 34", i, edges); end
            checks++; if (lo_out !== tq[i]) begin failures++; $display("[TB] FAIL signs_lo[%0d]: got %h expected %h", i, lo_out, tq[i]); end
            checks++; if (hi_out !== tr[i]) begin failures++; $display("[TB] FAIL signs_hi[%0d]: got %h expected %h", i, hi_out, tr[i]); end
            checks++; if (div_zero !== 1'b0) begin failures++; $display("[TB] FAIL signs_zero[%0d]: got %b expected 0", i, div_zero); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_div_zero;
        int edges;
        start_op(32'd100, 32'd7);
        wait_done(1, edges);
        @(posedge clk);
        #1;
        start_op(32'd5, 32'd0);
        checks++; if (div_end !== 1'b1) begin failures++; $display("[TB] FAIL zero_end: got %b expected 1", div_end); end
        checks++; if (div_zero !== 1'b1) begin failures++; $display("[TB] FAIL zero_flag: got %b expected 1", div_zero); end
        checks++; if (lo_out !== 32'd14) begin failures++; $display("[TB] FAIL zero_lo_hold: got %h expected %h", lo_out, 32'd14); end
        checks++; if (hi_out !== 32'd2) begin failures++; $display("[TB] FAIL zero_hi_hold: got %h expected %h", hi_out, 32'd2); end
        @(posedge clk);
        #1;
        checks++; if (div_end !== 1'b0) begin failures++; $display("[TB] FAIL zero_end_width: got %b expected 0", div_end); end
        checks++; if (div_zero !== 1'b1) begin failures++; $display("[TB] FAIL zero_flag_hold: got %b expected 1", div_zero); end
        start_op(32'd9, 32'd3);
        checks++; if (div_zero !== 1'b0) begin failures++; $display("[TB] FAIL zero_flag_clear: got %b expected 0", div_zero); end
        wait_done(1, edges);
        checks++; if (edges !== 34) begin failures++; $display("[TB] FAIL zero_next_latency: got %0d expected 34", edges); end
        checks++; if (lo_out !== 32'd3) begin failures++; $display("[TB] FAIL zero_next_lo: got %h expected %h", lo_out, 32'd3); end
        checks++; if (hi_out !== 32'd0) begin failures++; $display("[TB] FAIL zero_next_hi: got %h expected %h", hi_out, 32'd0); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ignore_start;
        int edges;
        start_op(32'd100, 32'd7);
        for (int e = 2; e <= 9; e++) begin
            @(posedge clk);
            #1;
        end
        div_control = 1'b1;
        a_in        = 32'd1;
        b_in        = 32'd1;
        @(posedge clk);
        #1;
        div_control = 1'b0;
        wait_done(10, edges);
        checks++; if (edges !== 34) begin failures++; $display("[TB] FAIL ignore_latency: got %0d expected 34", edges); end
        checks++; if (lo_out !== 32'd14) begin failures++; $display("[TB] FAIL ignore_lo: got %h expected %h", lo_out, 32'd14); end
        checks++; if (hi_out !== 32'd2) begin failures++; $display("[TB] FAIL ignore_hi: got %h expected %h", hi_out, 32'd2); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset;
        int edges;
        start_op(32'd100, 32'd7);
        wait_done(1, edges);
        @(posedge clk);
        #1;
        start_op(32'd100, 32'd7);
        for (int e = 2; e <= 10; e++) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (hi_out !== 32'd0) begin failures++; $display("[TB] FAIL midrst_hi: got %h expected %h", hi_out, 32'd0); end
        checks++; if (lo_out !== 32'd0) begin failures++; $display("[TB] FAIL midrst_lo: got %h expected %h", lo_out, 32'd0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (div_end !== 1'b0) begin failures++; $display("[TB] FAIL midrst_end: got %b expected 0", div_end); end
        @(negedge clk);
        reset = 1'b1;
        start_op(32'd20, 32'd6);
        wait_done(1, edges);
        checks++; if (edges !== 34) begin failures++; $display("[TB] FAIL midrst_latency: got %0d expected 34", edges); end
        checks++; if (lo_out !== 32'd3) begin failures++; $display("[TB] FAIL midrst_lo_after: got %h expected %h", lo_out, 32'd3); end
        checks++; if (hi_out !== 32'd2) begin failures++; $display("[TB] FAIL midrst_hi_after: got %h expected %h", hi_out, 32'd2); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int pulses;
        int first_edge;
        int second_edge;
        pulses      = 0;
        first_edge  = 0;
        second_edge = 0;
        @(negedge clk);
        a_in        = 32'd50;
        b_in        = 32'd5;
        div_control = 1'b1;
        for (int e = 1; e <= 80; e++) begin
            @(posedge clk);
            #1;
            if (div_end) begin
                pulses++;
                if (pulses == 1) first_edge = e;
                if (pulses == 2) second_edge = e;
                checks++; if (lo_out !== 32'd10) begin failures++; $display("[TB] FAIL b2b_lo[%0d]: got %h expected %h", e, lo_out, 32'd10); end
                checks++; if (hi_out !== 32'd0) begin failures++; $display("[TB] FAIL b2b_hi[%0d]: got %h expected %h", e, hi_out, 32'd0); end
            end
        end
        div_control = 1'b0;
        checks++; if (pulses !== 2) begin failures++; $display("[TB] FAIL b2b_pulses: got %0d expected 2", pulses); end
        checks++; if (first_edge !== 34) begin failures++; $display("[TB] FAIL b2b_first: got %0d expected 34", first_edge); end
        checks++; if (second_edge - first_edge !== 35) begin failures++; $display("[TB] FAIL b2b_spacing: got %0d expected 35", second_edge - first_edge); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
